// File: rtl/jdrosent_edge_pulse_gen_pkg.sv
// Shared definitions for the edge pulse generator: FSM state encoding and
// default widths for the pulse-count and phase-length configuration.
// Optional feature macro used by the top: PULSE_GEN_REPEAT_EN.
package jdrosent_edge_pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned LEN_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } pulse_state_e;

endpackage

// File: rtl/jdrosent_phase_counter.sv
// Loadable down-counter timing one high or low phase.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (priority over en)
//   en         : decrement by one, holds at zero (no wrap)
//   load_val   : phase length minus one
//   zero_c     : counter is at its terminal value
module jdrosent_phase_counter #(
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [LEN_W-1:0] load_val,
  output logic             zero_c
);

  logic [LEN_W-1:0] cnt_q;

  // Down-count with load priority; terminal value sticks at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/jdrosent_edge_pulse_gen.sv
// Programmable burst generator: emits count rising edges on pulse_o, each
// high for high_len+1 cycles and low for low_len+1 cycles, then a one-cycle
// done strobe. Config is latched at launch; start is edge-triggered and only
// honoured while idle.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : burst request (0->1 sampled on clk)
//   count               : pulses per burst (0 -> straight to done)
//   high_len, low_len   : phase lengths minus one
//   pulse_o             : registered pulse train
//   busy                : high from launch through the done cycle
//   done                : one-cycle end-of-burst strobe
//   repeat_en           : only with PULSE_GEN_REPEAT_EN; relaunch from done
module jdrosent_edge_pulse_gen
  import jdrosent_edge_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  output logic             pulse_o,
  output logic             busy,
  output logic             done
`ifdef PULSE_GEN_REPEAT_EN
  ,
  input  logic             repeat_en
`endif
);

  pulse_state_e     state_q, state_nxt;
  logic             start_q;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic [LEN_W-1:0] cfg_high_q, cfg_high_nxt;
  logic [LEN_W-1:0] cfg_low_q, cfg_low_nxt;
`ifdef PULSE_GEN_REPEAT_EN
  logic [CNT_W-1:0] cfg_cnt_q, cfg_cnt_nxt;
`endif
  logic             pulse_nxt, busy_nxt, done_nxt;
  logic             launch_c;
  logic             ph_load, ph_en, ph_zero_c;
  logic [LEN_W-1:0] ph_val;

  assign launch_c = start & ~start_q & (state_q == ST_IDLE);

  jdrosent_phase_counter #(.LEN_W(LEN_W)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_val),
    .zero_c   (ph_zero_c)
  );

  // State, latched config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      rem_q      <= '0;
      cfg_high_q <= '0;
      cfg_low_q  <= '0;
`ifdef PULSE_GEN_REPEAT_EN
      cfg_cnt_q  <= '0;
`endif
      pulse_o    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      start_q    <= start;
      rem_q      <= rem_nxt;
      cfg_high_q <= cfg_high_nxt;
      cfg_low_q  <= cfg_low_nxt;
`ifdef PULSE_GEN_REPEAT_EN
      cfg_cnt_q  <= cfg_cnt_nxt;
`endif
      pulse_o    <= pulse_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Next state, phase-counter control and next outputs
  always_comb begin
    state_nxt    = state_q;
    rem_nxt      = rem_q;
    cfg_high_nxt = cfg_high_q;
    cfg_low_nxt  = cfg_low_q;
`ifdef PULSE_GEN_REPEAT_EN
    cfg_cnt_nxt  = cfg_cnt_q;
`endif
    ph_load      = 1'b0;
    ph_en        = 1'b0;
    ph_val       = cfg_high_q;

    unique case (state_q)
      ST_IDLE: begin
        if (launch_c) begin
          cfg_high_nxt = high_len;
          cfg_low_nxt  = low_len;
`ifdef PULSE_GEN_REPEAT_EN
          cfg_cnt_nxt  = count;
`endif
          rem_nxt      = count;
          if (count != '0) begin
            state_nxt = ST_HIGH;
            ph_load   = 1'b1;
            ph_val    = high_len;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (ph_zero_c) begin
          state_nxt = ST_LOW;
          ph_load   = 1'b1;
          ph_val    = cfg_low_q;
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (ph_zero_c) begin
          // Last pulse when one remains; remaining count never underflows
          if (rem_q > CNT_W'(1)) begin
            rem_nxt   = rem_q - CNT_W'(1);
            state_nxt = ST_HIGH;
            ph_load   = 1'b1;
            ph_val    = cfg_high_q;
          end else begin
            rem_nxt   = '0;
            state_nxt = ST_DONE;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
`ifdef PULSE_GEN_REPEAT_EN
        if (repeat_en) begin
          rem_nxt = cfg_cnt_q;
          if (cfg_cnt_q != '0) begin
            state_nxt = ST_HIGH;
            ph_load   = 1'b1;
            ph_val    = cfg_high_q;
          end else begin
            state_nxt = ST_DONE;
          end
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase

    pulse_nxt = (state_nxt == ST_HIGH);
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
  end

endmodule
